// File: rtl/ebi_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ebi_tx_arb_if
// Description : Channel request / beat / credit bundle for the EBI TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ebi_tx_arb_if #(
    parameter int TX_CHANNEL_NUM    = 5,
    parameter int CHANNEL_NUM_WIDTH = 3,
    parameter int LEN_WIDTH         = 3,
    parameter int CREDIT_WIDTH      = 4
) ();
    logic [TX_CHANNEL_NUM-1:0]           ch_req_i;
    logic [TX_CHANNEL_NUM*LEN_WIDTH-1:0] ch_len_i;
    logic [TX_CHANNEL_NUM-1:0]           ch_grant_o;
    logic                                beat_v_o;
    logic [CHANNEL_NUM_WIDTH-1:0]        beat_ch_o;
    logic [LEN_WIDTH-1:0]                beat_idx_o;
    logic                                sop_o;
    logic                                eop_o;
    logic                                credit_in_i;
    logic [CREDIT_WIDTH-1:0]             credit_cnt_o;
    logic                                credit_ovf_o;
    logic                                busy_o;

    modport slave (
        input  ch_req_i, ch_len_i, credit_in_i,
        output ch_grant_o, beat_v_o, beat_ch_o, beat_idx_o, sop_o, eop_o,
               credit_cnt_o, credit_ovf_o, busy_o
    );

    modport master (
        output ch_req_i, ch_len_i, credit_in_i,
        input  ch_grant_o, beat_v_o, beat_ch_o, beat_idx_o, sop_o, eop_o,
               credit_cnt_o, credit_ovf_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/ebi_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : ebi_tx_arb
// Description : Round-robin channel arbiter and credit-gated beat sequencer
//               for the shared off-die EBI transmit link.
// Revision    : 1.0 - initial release
// ============================================================================
module ebi_tx_arb #(
    parameter int TX_CHANNEL_NUM    = 5,
    parameter int CHANNEL_NUM_WIDTH = 3,
    parameter int LEN_WIDTH         = 3,
    parameter int CREDIT_WIDTH      = 4,
    parameter int CREDIT_INIT       = 8
) (
    input  wire logic         bus_clk,
    input  wire logic         rst,
    ebi_tx_arb_if.slave       bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [CREDIT_WIDTH-1:0]      c_credit_max  = '1;
    localparam logic [CREDIT_WIDTH-1:0]      c_credit_init = CREDIT_WIDTH'(CREDIT_INIT);
    localparam logic [CHANNEL_NUM_WIDTH-1:0] c_last_ch     = CHANNEL_NUM_WIDTH'(TX_CHANNEL_NUM - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [TX_CHANNEL_NUM-1:0]      r_grant;
    logic [CHANNEL_NUM_WIDTH-1:0]   r_ch;
    logic [LEN_WIDTH-1:0]           r_len;
    logic [LEN_WIDTH-1:0]           r_cnt;
    logic [CHANNEL_NUM_WIDTH-1:0]   r_ptr;
    logic [CREDIT_WIDTH-1:0]        r_credit;
    logic                           r_ovf;

    logic                           w_any;
    logic [CHANNEL_NUM_WIDTH-1:0]   w_win;
    logic [CHANNEL_NUM_WIDTH-1:0]   w_cand;
    logic [LEN_WIDTH-1:0]           w_len;
    logic [TX_CHANNEL_NUM-1:0]      w_grant_oh;
    logic                           w_beat;
    logic                           w_last;
    logic [CHANNEL_NUM_WIDTH-1:0]   w_ptr_nxt;

    // Scan requesters starting at the pointer and wrapping; first hit wins.
    always_comb begin
        int pos;
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        pos    = 0;
        for (int i = 0; i < TX_CHANNEL_NUM; i++) begin
            pos = int'(r_ptr) + i;
            if (pos >= TX_CHANNEL_NUM) begin
                pos = pos - TX_CHANNEL_NUM;
            end
            w_cand = CHANNEL_NUM_WIDTH'(pos);
            if (!w_any && bus.ch_req_i[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    always_comb begin
        w_len      = '0;
        w_grant_oh = '0;
        for (int i = 0; i < TX_CHANNEL_NUM; i++) begin
            if (w_win == CHANNEL_NUM_WIDTH'(i)) begin
                w_len         = bus.ch_len_i[i*LEN_WIDTH +: LEN_WIDTH];
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    assign w_beat    = (r_state == S_SEND) && (r_credit != '0);
    assign w_last    = (r_cnt == r_len);
    assign w_ptr_nxt = (r_ch == c_last_ch) ? '0 : r_ch + 1'b1;

    always_ff @(posedge bus_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_beat && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge rst) begin
        if (!rst) begin
            r_grant  <= '0;
            r_ch     <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_credit <= c_credit_init;
            r_ovf    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_grant <= w_grant_oh;
                r_ch    <= w_win;
                r_len   <= w_len;
                r_cnt   <= '0;
            end else if (w_beat) begin
                if (w_last) begin
                    r_grant <= '0;
                    r_cnt   <= '0;
                    r_ptr   <= w_ptr_nxt;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            // A returned credit and an issued beat in the same cycle cancel.
            case ({bus.credit_in_i, w_beat})
                2'b10: begin
                    if (r_credit == c_credit_max) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_credit <= r_credit + 1'b1;
                    end
                end
                2'b01:   r_credit <= r_credit - 1'b1;
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign bus.ch_grant_o   = r_grant;
    assign bus.beat_v_o     = w_beat;
    assign bus.beat_ch_o    = r_ch;
    assign bus.beat_idx_o   = r_cnt;
    assign bus.sop_o        = w_beat && (r_cnt == '0);
    assign bus.eop_o        = w_beat && w_last;
    assign bus.credit_cnt_o = r_credit;
    assign bus.credit_ovf_o = r_ovf;
    assign bus.busy_o       = (r_state == S_SEND);

endmodule
`default_nettype wire

// File: tb/tb_ebi_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ebi_tx_arb
// Description : Scoreboard bench for the EBI TX round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ebi_tx_arb;

    localparam int N   = 5;
    localparam int CW  = 3;
    localparam int LW  = 3;
    localparam int CRW = 4;

    typedef struct {
        logic [CW-1:0] ch;
        logic [LW-1:0] idx;
        logic          sop;
        logic          eop;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] len = '0;
    logic            credit_in = 1'b0;
    logic            auto_refill = 1'b0;

    beat_t q[$];
    int    beat_cyc[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    ebi_tx_arb_if #(.TX_CHANNEL_NUM(N), .CHANNEL_NUM_WIDTH(CW),
                    .LEN_WIDTH(LW), .CREDIT_WIDTH(CRW)) bus_if ();

    assign bus_if.ch_req_i    = req;
    assign bus_if.ch_len_i    = len;
    assign bus_if.credit_in_i = credit_in;

    ebi_tx_arb #(.TX_CHANNEL_NUM(N), .CHANNEL_NUM_WIDTH(CW), .LEN_WIDTH(LW),
                 .CREDIT_WIDTH(CRW), .CREDIT_INIT(8)) dut (
        .bus_clk (clk),
        .rst     (rst),
        .bus     (bus_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pop the expected beat for every issued beat; the requester drops on eop.
    task automatic monitor();
        beat_t e;
        if (bus_if.beat_v_o) begin
            beat_cyc.push_back(cyc);
            if (q.size() == 0) begin
                check("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("beat_ch",  32'(bus_if.beat_ch_o),  32'(e.ch));
                check("beat_idx", 32'(bus_if.beat_idx_o), 32'(e.idx));
                check("sop",      32'(bus_if.sop_o),      32'(e.sop));
                check("eop",      32'(bus_if.eop_o),      32'(e.eop));
                check("grant",    32'(bus_if.ch_grant_o), 32'(1) << e.ch);
                if (e.eop) req[e.ch] = 1'b0;
            end
            if (auto_refill) credit_in = 1'b1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        credit_in = 1'b0;
        cyc++;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic send(input int ch, input int l);
        beat_t e;
        req[ch]            = 1'b1;
        len[ch*LW +: LW]   = LW'(l);
        for (int i = 0; i <= l; i++) begin
            e.ch  = CW'(ch);
            e.idx = LW'(i);
            e.sop = (i == 0);
            e.eop = (i == l);
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            check({tag, "_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
            req = '0;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        credit_in = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},  32'(bus_if.ch_grant_o),   32'd0);
        check({tag, "_beat_v"}, 32'(bus_if.beat_v_o),     32'd0);
        check({tag, "_idx"},    32'(bus_if.beat_idx_o),   32'd0);
        check({tag, "_sop"},    32'(bus_if.sop_o),        32'd0);
        check({tag, "_eop"},    32'(bus_if.eop_o),        32'd0);
        check({tag, "_busy"},   32'(bus_if.busy_o),       32'd0);
        check({tag, "_credit"}, 32'(bus_if.credit_cnt_o), 32'd8);
        check({tag, "_ovf"},    32'(bus_if.credit_ovf_o), 32'd0);
    endtask

    initial begin
        int req_cyc;
        int pulse_cyc;
        int n;
        bit hit;

        // Reset state
        @(negedge clk);
        check_idle_outputs("reset");
        do_reset();

        // Single message, ch0 len 3, latency and credit spend
        req_cyc = cyc;
        beat_cyc.delete();
        send(0, 3);
        wait_done("msg1");
        check("msg1_first_beat_cyc", 32'(beat_cyc[0]), 32'(req_cyc + 1));
        check("msg1_last_beat_cyc",  32'(beat_cyc[$]), 32'(req_cyc + 4));
        check("msg1_busy_drop",      32'(bus_if.busy_o), 32'd0);
        check("msg1_credit",         32'(bus_if.credit_cnt_o), 32'd4);

        // All five channels, len 0, credits refilled with every beat
        do_reset();
        auto_refill = 1'b1;
        beat_cyc.delete();
        for (int c = 0; c < N; c++) send(c, 0);
        wait_done("rr5");
        for (int i = 0; i < 4; i++) begin
            check("rr5_gap", 32'(beat_cyc[i+1] - beat_cyc[i]), 32'd2);
        end
        check("rr5_credit", 32'(bus_if.credit_cnt_o), 32'd8);
        // Pointer back at 0: ch0 beats ch2
        send(0, 0);
        send(2, 0);
        wait_done("rr_02");
        // Pointer at 3: ch4 wins, then wrap to ch1
        send(4, 0);
        send(1, 0);
        wait_done("rr_41");
        check("rr_credit", 32'(bus_if.credit_cnt_o), 32'd8);
        auto_refill = 1'b0;

        // Drain credits to 2 with a 6-beat message
        send(1, 5);
        wait_done("drain");
        check("drain_credit", 32'(bus_if.credit_cnt_o), 32'd2);

        // Credit starvation: 2 beats then stall with grant held
        send(3, 5);
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 50) begin
            tick();
            n++;
            if (q.size() == 4) hit = 1'b1;
        end
        check("stall_reach", 32'(hit), 32'd1);
        for (int k = 0; k < 3; k++) begin
            sample();
            check("stall_beat_v", 32'(bus_if.beat_v_o),     32'd0);
            check("stall_grant",  32'(bus_if.ch_grant_o),   32'b01000);
            check("stall_busy",   32'(bus_if.busy_o),       32'd1);
            check("stall_credit", 32'(bus_if.credit_cnt_o), 32'd0);
            advance();
        end
        credit_in = 1'b1;
        pulse_cyc = cyc;
        tick();
        // Beat issues with count 1 while another credit returns
        credit_in = 1'b1;
        sample();
        check("pulse_beat_cyc",   32'(beat_cyc[$]), 32'(pulse_cyc + 1));
        check("pulse_credit",     32'(bus_if.credit_cnt_o), 32'd1);
        advance();
        check("same_cycle_credit", 32'(bus_if.credit_cnt_o), 32'd1);
        auto_refill = 1'b1;
        wait_done("starve");
        auto_refill = 1'b0;
        check("starve_credit", 32'(bus_if.credit_cnt_o), 32'd1);

        // Overflow: fill to 15, one more return sets the sticky flag
        for (int k = 0; k < 14; k++) begin
            credit_in = 1'b1;
            tick();
        end
        check("fill_credit", 32'(bus_if.credit_cnt_o), 32'd15);
        check("fill_ovf",    32'(bus_if.credit_ovf_o), 32'd0);
        credit_in = 1'b1;
        tick();
        check("ovf_credit", 32'(bus_if.credit_cnt_o), 32'd15);
        check("ovf_set",    32'(bus_if.credit_ovf_o), 32'd1);
        tick();
        tick();
        check("ovf_sticky", 32'(bus_if.credit_ovf_o), 32'd1);

        // Reset during beat idx 2 of a ch2 message (pointer currently 4)
        send(2, 5);
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 50) begin
            sample();
            if (q.size() == 3) hit = 1'b1;
            else begin
                advance();
                n++;
            end
        end
        check("midreset_reach", 32'(hit), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        req = '0;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
        // Pointer must be 0 again: ch1 ahead of ch4
        send(1, 0);
        send(4, 0);
        wait_done("post_reset");
        check("post_reset_credit", 32'(bus_if.credit_cnt_o), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
